peak_topn_collector: RTL and testbench
======================================

# peak_topn_collector

Downstream consumer of `peak_doubles_shell`. Takes the packed peak words (`p_i_s`) produced during one frame and keeps the N largest peaks in a sorted register list. On the frame-end marker (`last_out`), it snapshots the list and drains it as an N-word ranked stream with a valid/ready handshake. It then collects the next frame while draining.

## Interface
Parameters:
- `VALUE_WIDTH`, default `` `VALUE_WIDTH ``: peak magnitude width, taken from the `p_i_s` packing.
- `INDEX_WIDTH`, default `` `INDEX_WIDTH ``: bin index width.
- `N`, default 4: list depth. Legal range 2..16.
- `RW`, default `$clog2(N)`: rank field width.

Ports:
- `clk`: in, 1. Sole clock.
- `aresetn`: in, 1. Reset is synchronous and active-low. Sampled on rising `clk`.
- `p_valid`: in, 1. `p_i_s` carries a peak this cycle.
- `p_i_s`: in, 32. Packed peak word:
  - `[31:32-VALUE_WIDTH]` = value
  - `[31-VALUE_WIDTH]` = side
  - `[INDEX_WIDTH-1:0]` = index
- `last_out`: in, 1. Frame end from the peak stage. A single-cycle pulse.
- `m_valid`: out, 1. Output word valid.
- `m_ready`: in, 1. Downstream accept.
- `m_data`: out, 32. Ranked peak word, same packing as `p_i_s`. Zero when `m_entry_valid` = 0.
- `m_entry_valid`: out, 1. The slot holds a real peak.
- `m_rank`: out, RW. 0 = largest.
- `m_last`: out, 1. Marks rank N-1.
- `drop_cnt`: out, 8. Saturating count of frames discarded because the drain was busy.

## Operation
- **Collect list:** N slots of {valid, value, side, index}, kept sorted in descending value order.
  - Empty slots sit below all filled slots.
  - Comparison is unsigned, on value only.
- **Insertion** (`p_valid`=1):
  - Compute position k = count of filled slots with value >= new value. Ties therefore rank the earlier arrival higher.
  - If k < N: slots k..N-2 shift down one, and the new entry is written to slot k. Slot N-1 is discarded.
  - If k = N: the peak is ignored.
- **Frame end** (`last_out`=1):
  - The collect list, including any peak accepted in the same cycle, is copied to the drain buffer.
  - The collect list is cleared in that same update.
- **Drain FSM:**
  - IDLE: on snapshot → SEND, with rank = 0.
  - SEND: present slot[rank]. On `m_valid & m_ready`, rank increments. On the handshake with rank = N-1 → IDLE.
- **Busy drain:**
  - A `last_out` arriving while the FSM is in SEND, and not in its final handshake cycle, discards the new frame's list.
  - The collect list is still cleared.
  - `drop_cnt` increments, saturating at 255.
  - A `last_out` coinciding with the final handshake (rank N-1 accepted) is accepted, and SEND restarts at rank 0.
- **Output words:** `m_data`, `m_rank`, `m_entry_valid` and `m_last` must be held stable while `m_valid=1 & m_ready=0`.
- **Empty frame:** N words are still emitted, all with `m_entry_valid`=0.

## Timing
- **Reset** (`aresetn`=0 at a rising edge), effective at that edge:
  - All list and buffer slots are cleared.
  - FSM goes to IDLE.
  - Outputs: `m_valid`=0, `m_data`=0, `m_entry_valid`=0, `m_rank`=0, `m_last`=0, `drop_cnt`=0.
  - A reset during SEND aborts the drain, with no further words.
- **Insertion:** a peak sampled at edge t is visible in the collect list after t.
- **Snapshot:** `last_out` sampled at edge t causes:
  - `m_valid`=1 with rank 0 from edge t+1.
  - Rank r at the earliest t+1+r (when `m_ready` is held high).
- **Throughput:** one insertion per cycle, sustained. Back-to-back `p_valid` with no bubbles is legal.
- **Drain restart:** after the final handshake, `m_valid` drops the next cycle unless a snapshot was taken in that same cycle.

## Test plan
- **Basic top-4:** N=4. Peaks in order with values 0xA34, 0x514, 0xB37, 0x2F3, 0xC34, 0x884, then `last_out`.
  - Required: ranks 0..3 = 0xC34, 0xB37, 0xA34, 0x884, all `m_entry_valid`=1.
  - `m_last` set on rank 3 only.
  - First word appears 1 cycle after `last_out`.
- **Tie ordering:** peaks 0xC3 at index 9, then 0xC3 at index 10, then 0x37, then `last_out`.
  - Required: rank 0 = index 9, rank 1 = index 10, rank 2 = 0x37, rank 3 `m_entry_valid`=0 with `m_data`=0.
- **Simultaneous peak and frame end:** `p_valid` with 0x1E3 in the same cycle as `last_out`.
  - Required: 0x1E3 appears in that frame's output.
  - Next frame starts empty.
- **Backpressure:** `m_ready` toggled 1,0,0,1,0,1,1 during drain.
  - Required: outputs stable while stalled.
  - Exactly 4 handshakes, in rank order 0..3.
  - No word lost or duplicated.
- **Drop and reset:** hold `m_ready`=0, then pulse `last_out` twice more.
  - Required: `drop_cnt`=2, and the drain buffer is unchanged.
  - Then assert `aresetn`=0 for 1 cycle: `m_valid`=0, `drop_cnt`=0 on the next cycle.
  - Then send an empty frame: 4 words, all `m_entry_valid`=0.

Source files
------------

// File: rtl/peak_topn_collector.sv
// peak_topn_collector: keeps the N largest peaks of a frame in a sorted
// register list. On frame end the list is snapshotted into a drain buffer
// and streamed out as N ranked words over a valid/ready handshake.

`ifndef VALUE_WIDTH
`define VALUE_WIDTH 16
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 10
`endif

module peak_topn_collector #(
    parameter int VALUE_WIDTH = `VALUE_WIDTH,
    parameter int INDEX_WIDTH = `INDEX_WIDTH,
    parameter int N           = 4,
    parameter int RW          = $clog2(N)
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          p_valid,
    input  logic [31:0]   p_i_s,
    input  logic          last_out,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [31:0]   m_data,
    output logic          m_entry_valid,
    output logic [RW-1:0] m_rank,
    output logic          m_last,
    output logic [7:0]    drop_cnt
);

    typedef struct packed {
        logic                   valid;
        logic [VALUE_WIDTH-1:0] value;
        logic                   side;
        logic [INDEX_WIDTH-1:0] index;
    } slot_t;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    slot_t  col_q [N];
    slot_t  col_d [N];
    slot_t  col_ins [N];
    slot_t  buf_q [N];
    slot_t  buf_d [N];
    slot_t  new_slot;
    slot_t  out_slot;
    logic [N-1:0] ge;

    state_t        state_q, state_d;
    logic [RW-1:0] rank_q, rank_d;
    logic [7:0]    drop_q, drop_d;

    logic fire;
    logic final_hs;
    logic snap;
    logic drop;
    logic unused_ok;

    // Bits of p_i_s between the side flag and the index field carry no information.
    assign unused_ok = ^p_i_s;

    assign new_slot.valid = 1'b1;
    assign new_slot.value = p_i_s[31 -: VALUE_WIDTH];
    assign new_slot.side  = p_i_s[31-VALUE_WIDTH];
    assign new_slot.index = p_i_s[INDEX_WIDTH-1:0];

    // Slots that stay above the newcomer: filled and value >= new value (ties keep the older peak higher).
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default first, so no path can infer a latch.
        ge = '0;
        for (int i = 0; i < N; i++) begin
            ge[i] = col_q[i].valid && (col_q[i].value >= new_slot.value);
        end
    end

    // Sorted insertion: slots above stay, the first non-ge slot takes the newcomer, the rest shift down.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            col_ins[i] = col_q[i];
        end
        if (p_valid) begin
            if (!ge[0]) begin
                col_ins[0] = new_slot;
            end
            for (int i = 1; i < N; i++) begin
                if (!ge[i]) begin
                    col_ins[i] = ge[i-1] ? new_slot : col_q[i-1];
                end
            end
        end
    end

    assign fire     = m_valid && m_ready;
    assign final_hs = fire && (rank_q == RW'(N-1));
    assign snap     = last_out && ((state_q == S_IDLE) || final_hs);
    assign drop     = last_out && !snap;

    // List and buffer next state: frame end clears the collector, a taken snapshot loads the drain buffer.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            col_d[i] = last_out ? '0 : col_ins[i];
            buf_d[i] = snap ? col_ins[i] : buf_q[i];
        end
        drop_d = drop_q;
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Drain FSM next state: a snapshot (re)starts at rank 0, each handshake advances the rank.
    always_comb begin
        state_d = state_q;
        rank_d  = rank_q;
        case (state_q)
            S_IDLE: begin
                if (snap) begin
                    state_d = S_SEND;
                    rank_d  = '0;
                end
            end
            S_SEND: begin
                if (snap) begin
                    rank_d = '0;
                end else if (final_hs) begin
                    state_d = S_IDLE;
                    rank_d  = '0;
                end else if (fire) begin
                    rank_d = rank_q + RW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                rank_d  = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!aresetn) begin
            // NOTE: the slot arrays are small flop arrays, reset so an aborted frame leaves no stale peaks behind.
            for (int i = 0; i < N; i++) begin
                col_q[i] <= '0;
                buf_q[i] <= '0;
            end
            state_q <= S_IDLE;
            rank_q  <= '0;
            drop_q  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                col_q[i] <= col_d[i];
                buf_q[i] <= buf_d[i];
            end
            state_q <= state_d;
            rank_q  <= rank_d;
            drop_q  <= drop_d;
        end
    end

    assign out_slot = buf_q[rank_q];

    // Output word: built purely from registers, so it holds steady while the sink stalls.
    always_comb begin
        m_data = '0;
        if (m_valid && out_slot.valid) begin
            m_data[31 -: VALUE_WIDTH]    = out_slot.value;
            m_data[31-VALUE_WIDTH]       = out_slot.side;
            m_data[INDEX_WIDTH-1:0]      = out_slot.index;
        end
    end

    assign m_valid       = (state_q == S_SEND);
    assign m_entry_valid = m_valid && out_slot.valid;
    assign m_rank        = rank_q;
    assign m_last        = m_valid && (rank_q == RW'(N-1));
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_peak_topn_collector.sv
// Directed bench for peak_topn_collector: a frame model pushes expected
// ranked words into a scoreboard queue; handshakes pop and compare them.

module tb_peak_topn_collector;

    localparam int VW = 16;
    localparam int IW = 10;
    localparam int N  = 4;
    localparam int RW = 2;

    logic          clk;
    logic          aresetn;
    logic          p_valid;
    logic [31:0]   p_i_s;
    logic          last_out;
    logic          m_valid;
    logic          m_ready;
    logic [31:0]   m_data;
    logic          m_entry_valid;
    logic [RW-1:0] m_rank;
    logic          m_last;
    logic [7:0]    drop_cnt;

    typedef struct {
        logic [31:0]   data;
        logic          ev;
        logic [RW-1:0] rank;
        logic          last;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] frame_peaks[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic          prev_stall = 1'b0;
    logic [31:0]   prev_data;
    logic          prev_ev;
    logic [RW-1:0] prev_rank;
    logic          prev_last;

    peak_topn_collector #(
        .VALUE_WIDTH(VW),
        .INDEX_WIDTH(IW),
        .N(N),
        .RW(RW)
    ) dut (
        .clk(clk),
        .aresetn(aresetn),
        .p_valid(p_valid),
        .p_i_s(p_i_s),
        .last_out(last_out),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_entry_valid(m_entry_valid),
        .m_rank(m_rank),
        .m_last(m_last),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] pk(input logic [VW-1:0] v, input logic s, input logic [IW-1:0] idx);
        logic [31:0] w;
        w = '0;
        w[31 -: VW] = v;
        w[31-VW]    = s;
        w[IW-1:0]   = idx;
        return w;
    endfunction

    // Reference ranking: repeatedly take the largest value, earliest arrival winning ties.
    task automatic close_frame();
        logic [31:0] pool[$];
        pool = frame_peaks;
        for (int r = 0; r < N; r++) begin
            exp_t e;
            int   best;
            e.rank = RW'(r);
            e.last = (r == N-1);
            if (pool.size() == 0) begin
                e.data = '0;
                e.ev   = 1'b0;
            end else begin
                best = 0;
                for (int i = 1; i < pool.size(); i++) begin
                    if (pool[i][31 -: VW] > pool[best][31 -: VW]) best = i;
                end
                e.data = pool[best];
                e.ev   = 1'b1;
                pool.delete(best);
            end
            sb.push_back(e);
        end
        frame_peaks.delete();
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (prev_stall) begin
            check("stall_data", m_data, prev_data);
            check("stall_ev", 32'(m_entry_valid), 32'(prev_ev));
            check("stall_rank", 32'(m_rank), 32'(prev_rank));
            check("stall_last", 32'(m_last), 32'(prev_last));
        end
        if (aresetn && m_valid && m_ready) begin
            n_checks++;
            assert (sb.size() > 0) n_pass++;
            else $error("FAIL unexpected_word: observed rank %0d expected no word", m_rank);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("word_data", m_data, e.data);
                check("word_ev", 32'(m_entry_valid), 32'(e.ev));
                check("word_rank", 32'(m_rank), 32'(e.rank));
                check("word_last", 32'(m_last), 32'(e.last));
            end
        end
        prev_stall = aresetn && m_valid && !m_ready;
        prev_data  = m_data;
        prev_ev    = m_entry_valid;
        prev_rank  = m_rank;
        prev_last  = m_last;
        @(posedge clk);
        #1;
    endtask

    task automatic send_peak(input logic [VW-1:0] v, input logic s, input logic [IW-1:0] idx);
        p_valid = 1'b1;
        p_i_s   = pk(v, s, idx);
        frame_peaks.push_back(p_i_s);
        cycle();
        p_valid = 1'b0;
        p_i_s   = '0;
    endtask

    task automatic end_frame(input bit accept, input bit with_peak, input logic [31:0] peak);
        last_out = 1'b1;
        if (with_peak) begin
            p_valid = 1'b1;
            p_i_s   = peak;
            frame_peaks.push_back(peak);
        end
        if (accept) close_frame();
        else frame_peaks.delete();
        cycle();
        last_out = 1'b0;
        p_valid  = 1'b0;
        p_i_s    = '0;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() > 0; i++) cycle();
        check("drain_done", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        aresetn  = 1'b0;
        p_valid  = 1'b0;
        p_i_s    = '0;
        last_out = 1'b0;
        m_ready  = 1'b0;
        cycle();
        cycle();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_m_ev", 32'(m_entry_valid), 32'd0);
        check("rst_m_rank", 32'(m_rank), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        aresetn = 1'b1;
        cycle();

        // Basic top-4 with free-flowing sink.
        m_ready = 1'b1;
        send_peak(16'h0A34, 1'b0, 10'd1);
        send_peak(16'h0514, 1'b1, 10'd2);
        send_peak(16'h0B37, 1'b0, 10'd3);
        send_peak(16'h02F3, 1'b1, 10'd4);
        send_peak(16'h0C34, 1'b0, 10'd5);
        send_peak(16'h0884, 1'b1, 10'd6);
        end_frame(1'b1, 1'b0, 32'd0);
        check("first_word_latency", 32'(m_valid), 32'd1);
        check("first_word_rank", 32'(m_rank), 32'd0);
        drain(20);
        check("idle_after_drain", 32'(m_valid), 32'd0);

        // Tie ordering.
        send_peak(16'h00C3, 1'b0, 10'd9);
        send_peak(16'h00C3, 1'b1, 10'd10);
        send_peak(16'h0037, 1'b0, 10'd11);
        end_frame(1'b1, 1'b0, 32'd0);
        drain(20);

        // Peak in the frame-end cycle, then an empty frame.
        send_peak(16'h0100, 1'b0, 10'd1);
        end_frame(1'b1, 1'b1, pk(16'h01E3, 1'b1, 10'd2));
        drain(20);
        end_frame(1'b1, 1'b0, 32'd0);
        drain(20);

        // Backpressure pattern.
        send_peak(16'h0450, 1'b0, 10'd20);
        send_peak(16'h0990, 1'b1, 10'd21);
        send_peak(16'h0120, 1'b0, 10'd22);
        send_peak(16'h0770, 1'b1, 10'd23);
        send_peak(16'h0660, 1'b0, 10'd24);
        m_ready = 1'b0;
        end_frame(1'b1, 1'b0, 32'd0);
        begin
            logic bp_pat [7];
            bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
            for (int i = 0; i < 7; i++) begin
                m_ready = bp_pat[i];
                cycle();
            end
        end
        check("bp_all_words", 32'(sb.size()), 32'd0);
        check("bp_idle", 32'(m_valid), 32'd0);

        // Drops while stalled, then reset mid-drain, then an empty frame.
        m_ready = 1'b0;
        send_peak(16'h0700, 1'b0, 10'd1);
        send_peak(16'h0300, 1'b1, 10'd2);
        end_frame(1'b1, 1'b0, 32'd0);
        check("drop_frame_valid", 32'(m_valid), 32'd1);
        cycle();
        cycle();
        send_peak(16'h0FFF, 1'b0, 10'd3);
        end_frame(1'b0, 1'b0, 32'd0);
        end_frame(1'b0, 1'b0, 32'd0);
        check("drop_cnt_two", 32'(drop_cnt), 32'd2);
        check("drop_buf_data", m_data, sb[0].data);
        check("drop_buf_rank", 32'(m_rank), 32'd0);
        check("drop_buf_ev", 32'(m_entry_valid), 32'd1);
        aresetn = 1'b0;
        sb.delete();
        frame_peaks.delete();
        cycle();
        aresetn = 1'b1;
        check("rst2_m_valid", 32'(m_valid), 32'd0);
        check("rst2_drop", 32'(drop_cnt), 32'd0);
        cycle();
        check("rst2_still_idle", 32'(m_valid), 32'd0);
        m_ready = 1'b1;
        end_frame(1'b1, 1'b0, 32'd0);
        drain(20);
        check("final_idle", 32'(m_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
